mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Load/store stage directly downstream of the execute stage.
- Consumes the ALU result as an effective address (or as a pass-through result), together with rs2 store data and decoded memory controls.
- Drives a req/gnt/rvalid data-memory bus, aligns and sign-extends load data, and presents one registered result per instruction to write-back.
- Stalls upstream through a valid/ready handshake while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 255, max cycles waiting for dmem_gnt or dmem_rvalid before the access is aborted with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute-stage result valid
- in_ready  out  1  stage can accept an instruction this cycle
- alu_out  in  32  ALU result: effective address for loads/stores, else the result value
- rs2_data  in  32  store data
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store; mem_read and mem_write never both 1
- mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- mem_unsigned  in  1  zero-extend the load (LBU/LHU)
- rd_addr  in  5  destination register
- rd_we  in  1  destination write enable
- out_valid  out  1  write-back result valid (single-cycle pulse per instruction)
- out_data  out  32  load data or passed-through alu_out
- out_rd_addr  out  5  registered rd_addr
- out_rd_we  out  1  registered rd_we, forced to 0 on an exception
- misaligned  out  1  exception flag, qualified by out_valid
- bus_err  out  1  timeout exception flag, qualified by out_valid
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address, {alu_out[31:2],2'b00}
- dmem_wdata  out  32  store data replicated into byte lanes
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response valid; required for both reads and writes
- dmem_rdata  in  32  read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, out_valid=0, dmem_req=0, misaligned=0, bus_err=0, out_rd_we=0, out_data=0, timeout counter=0.
  - in_ready=1 after reset.
  - Reset asserted mid-transaction drops the request immediately; any later rvalid is ignored.
- Acceptance: an instruction is accepted when in_valid && in_ready; in_ready=1 only in IDLE.
- Non-memory instruction:
  - Registered pass-through: out_valid=1 the next cycle with out_data=alu_out.
  - Latency 1; throughput 1 per cycle.
- Alignment check at accept:
  - half with addr[0]=1 is misaligned; word/reserved with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no bus request. Next cycle: out_valid=1, misaligned=1, out_rd_we=0, out_data=alu_out.
- Byte enables and store data:
  - byte: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - half: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - word: be=4'b1111, wdata=rs2.
  - Loads drive the same be.
- FSM states IDLE, REQ, RESP:
  - IDLE -> REQ on accept of an aligned load/store. dmem_req=1 from the next cycle.
  - In REQ, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_gnt.
  - REQ -> RESP on dmem_gnt. dmem_req drops the following cycle.
  - RESP -> IDLE on dmem_rvalid. out_valid=1 in the same cycle, registered from rvalid.
  - Stores: out_rd_we=0. Loads: out_rd_we=rd_we.
  - gnt and rvalid in the same cycle while in REQ are legal: go straight to IDLE with the result.
  - Minimum load latency from accept to out_valid is 2 cycles.
- Load extraction:
  - Select the byte at rdata[8*addr[1:0]+:8], or the half at addr[1]?rdata[31:16]:rdata[15:0].
  - Sign-extend unless mem_unsigned; word loads take rdata unchanged.
  - The address offset and size are latched at accept.
- Timeout:
  - The counter resets on entry to REQ and on entry to RESP, and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT (if TIMEOUT!=0): go to IDLE and drop dmem_req. Emit out_valid=1, bus_err=1, out_rd_we=0, out_data=0.
  - A late rvalid arriving in IDLE is ignored.
- Outputs out_* are stable for exactly one cycle; there is no backpressure from write-back.

Test Plan:
- ALU passthrough: alu_out=0x1234_5678, no mem op, rd_addr=5 -> next cycle out_valid=1, out_data=0x1234_5678, out_rd_we=1, out_rd_addr=5; 3 back-to-back instructions produce 3 consecutive out_valid.
- LB sign-extend: addr=0x103, rdata=0x80AA_BBCC, gnt and rvalid one cycle apart -> dmem_addr=0x100, be=4'b1000, out_data=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH at 0x202, rs2=0xDEAD_BEEF -> be=4'b1100, wdata=0xBEEF_BEEF, dmem_we=1, out_rd_we=0; in_ready=0 until rvalid.
- Misaligned LW at 0x101 -> no dmem_req, next cycle out_valid=1, misaligned=1, out_rd_we=0.
- gnt held low 3 cycles -> dmem_req/addr/be held stable; same-cycle gnt+rvalid -> out_valid on the next edge, state IDLE.
- TIMEOUT=4, never grant -> bus_err=1 with out_valid after 4 cycles in REQ; rst_n pulsed low mid-RESP -> dmem_req=0 and out_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/mem_access.sv
// Load/store stage between execute and write-back: drives a req/gnt/rvalid data
// bus, aligns and extends load data, and returns one registered result per instruction.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd_addr,
    input  logic        rd_we,

    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd_addr,
    output logic        out_rd_we,
    output logic        misaligned,
    output logic        bus_err,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    localparam logic          T_ON   = (TIMEOUT != 0);

    state_t        state;
    logic [CW-1:0] tcnt;

    // Per-transaction context captured at accept.
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_uns;
    logic          lat_load;
    logic          lat_rd_we;

    logic          is_mem;
    logic          acc_mis;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic          done;
    logic          expired;

    // NOTE: in_ready is decoded straight from the state register, so it can be
    // used by upstream in the same cycle without adding a pipeline bubble.
    assign in_ready = (state == IDLE);
    assign is_mem   = mem_read | mem_write;

    // Accept-time decode of alignment, byte lanes and replicated store data.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        acc_mis   = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = rs2_data;
        unique case (mem_size)
            2'd0: begin
                acc_be    = 4'b0001 << alu_out[1:0];
                acc_wdata = {4{rs2_data[7:0]}};
            end
            2'd1: begin
                acc_mis   = alu_out[0];
                acc_be    = alu_out[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                acc_mis = |alu_out[1:0];
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        byte_sel  = dmem_rdata[{lat_off, 3'b000} +: 8];
        half_sel  = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        unique case (lat_size)
            2'd0:    load_data = {{24{~lat_uns & byte_sel[7]}}, byte_sel};
            2'd1:    load_data = {{16{~lat_uns & half_sel[15]}}, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // A response in REQ only counts together with its grant.
    assign done    = ((state == REQ) && dmem_gnt && dmem_rvalid) ||
                     ((state == RESP) && dmem_rvalid);
    assign expired = T_ON && (tcnt == T_LAST);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tcnt        <= '0;
            lat_off     <= 2'd0;
            lat_size    <= 2'd0;
            lat_uns     <= 1'b0;
            lat_load    <= 1'b0;
            lat_rd_we   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_rd_addr <= 5'd0;
            out_rd_we   <= 1'b0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            dmem_be     <= 4'd0;
        end else begin
            // Write-back outputs are single-cycle pulses unless refreshed below.
            out_valid  <= 1'b0;
            out_rd_we  <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_rd_addr <= rd_addr;
                        if (!is_mem) begin
                            out_valid <= 1'b1;
                            out_data  <= alu_out;
                            out_rd_we <= rd_we;
                        end else if (acc_mis) begin
                            out_valid  <= 1'b1;
                            misaligned <= 1'b1;
                            out_data   <= alu_out;
                        end else begin
                            state      <= REQ;
                            tcnt       <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_out[31:2], 2'b00};
                            dmem_be    <= acc_be;
                            dmem_wdata <= acc_wdata;
                            lat_off    <= alu_out[1:0];
                            lat_size   <= mem_size;
                            lat_uns    <= mem_unsigned;
                            lat_load   <= mem_read;
                            lat_rd_we  <= mem_read & rd_we;
                        end
                    end
                end

                REQ, RESP: begin
                    if (done) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= lat_load ? load_data : 32'd0;
                        out_rd_we <= lat_rd_we;
                    end else if ((state == REQ) && dmem_gnt) begin
                        state    <= RESP;
                        dmem_req <= 1'b0;
                        tcnt     <= '0;
                    end else if (expired) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        out_valid <= 1'b1;
                        bus_err   <= 1'b1;
                        out_data  <= 32'd0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a per-instruction result model feeds a queue that a
// negedge compare process checks against every out_valid pulse.
module tb_mem_access;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic        misaligned;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .rd_addr      (rd_addr),
        .rd_we        (rd_we),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rd_addr  (out_rd_addr),
        .out_rd_we    (out_rd_we),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mis;
        logic        berr;
    } wb_t;

    wb_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    logic [31:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    logic        last_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: results computed from the architectural rules ----
    function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            default: return off != 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] rs2);
        case (sz)
            2'd0:    return {24'h0, rs2[7:0]} * 32'h0101_0101;
            2'd1:    return {16'h0, rs2[15:0]} * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                           input logic uns, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rdata >> {off, 3'b000};
        case (sz)
            2'd0: begin
                v = sh & 32'h0000_00FF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = sh & 32'h0000_FFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // ---- compare process: every write-back pulse must match the model ----
    always @(negedge clk) begin
        wb_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk_data) check("wb_data", out_data, e.data);
                check("wb_rd_addr", 32'(out_rd_addr), 32'(e.rd));
                check("wb_rd_we", 32'(out_rd_we), 32'(e.rd_we));
                check("wb_misaligned", 32'(misaligned), 32'(e.mis));
                check("wb_bus_err", 32'(bus_err), 32'(e.berr));
            end
        end
    end

    // Drives one instruction and plays the memory side with the given delays.
    // rv_dly = 0 returns rvalid together with gnt; no_gnt never grants.
    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2,
                         input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [4:0] rd, input logic we,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                         input bit no_gnt);
        wb_t        e;
        logic [1:0] off;
        bit         is_mem;
        bit         mis;
        int         n;
        off    = alu[1:0];
        is_mem = ld || st;
        mis    = is_mem && m_mis(sz, off);
        e.rd       = rd;
        e.mis      = mis;
        e.berr     = 1'b0;
        e.chk_data = 1'b1;
        if (!is_mem) begin
            e.data  = alu;
            e.rd_we = we;
        end else if (mis) begin
            e.data  = alu;
            e.rd_we = 1'b0;
        end else if (no_gnt) begin
            e.data  = 32'd0;
            e.rd_we = 1'b0;
            e.berr  = 1'b1;
        end else begin
            e.data     = m_load(sz, off, uns, rdata);
            e.chk_data = ld;
            e.rd_we    = ld && we;
        end
        exp_q.push_back(e);

        alu_out = alu; rs2_data = rs2; mem_read = ld; mem_write = st;
        mem_size = sz; mem_unsigned = uns; rd_addr = rd; rd_we = we;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

        if (!is_mem || mis) begin
            check("one_cycle_result", 32'(out_valid), 32'd1);
            check("no_bus_req", 32'(dmem_req), 32'd0);
            return;
        end

        last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
        check("req_issued", 32'(dmem_req), 32'd1);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("req_addr", dmem_addr, {alu[31:2], 2'b00});
        check("req_be", 32'(dmem_be), 32'(m_be(sz, off)));
        check("req_we", 32'(dmem_we), 32'(st));
        if (st) check("req_wdata", dmem_wdata, m_wdata(sz, rs2));

        if (no_gnt) begin
            n = 0;
            while (!out_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(TMO));
            check("timeout_bus_err", 32'(bus_err), 32'd1);
            check("timeout_req_drop", 32'(dmem_req), 32'd0);
            return;
        end

        repeat (gnt_dly) begin
            @(posedge clk); #1;
            check("hold_req", 32'(dmem_req), 32'd1);
            check("hold_addr", dmem_addr, last_addr);
            check("hold_be", 32'(dmem_be), 32'(last_be));
            check("hold_wdata", dmem_wdata, last_wdata);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        dmem_gnt = 1'b1;
        if (rv_dly == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (rv_dly > 0) begin
            check("req_drop_after_gnt", 32'(dmem_req), 32'd0);
            check("resp_in_ready", 32'(in_ready), 32'd0);
            repeat (rv_dly - 1) begin
                @(posedge clk); #1;
                check("resp_wait_in_ready", 32'(in_ready), 32'd0);
                check("resp_wait_no_result", 32'(out_valid), 32'd0);
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
        check("result_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("done_req_low", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_t e;
        rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; rs2_data = '0; mem_read = 1'b0;
        mem_write = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0; rd_addr = '0; rd_we = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_out_rd_we", 32'(out_rd_we), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU pass-through
        issue(32'h1234_5678, 32'd0, 0, 0, 2'd2, 0, 5'd5, 1, 32'd0, 0, 0, 0);
        check("pass_data", out_data, 32'h1234_5678);
        check("pass_rd_addr", 32'(out_rd_addr), 32'd5);
        check("pass_rd_we", 32'(out_rd_we), 32'd1);

        // three back-to-back pass-through instructions
        for (int i = 0; i < 3; i++) begin
            e.data = 32'h1000_0000 + 32'(i); e.chk_data = 1'b1; e.rd = 5'(i + 1);
            e.rd_we = 1'b1; e.mis = 1'b0; e.berr = 1'b0;
            exp_q.push_back(e);
            alu_out = e.data; rd_addr = e.rd; rd_we = 1'b1; in_valid = 1'b1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            check("b2b_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_pulse_ends", 32'(out_valid), 32'd0);

        // LB / LBU at 0x103, gnt then rvalid one cycle later
        issue(32'h0000_0103, 32'd0, 1, 0, 2'd0, 0, 5'd7, 1, 32'h80AA_BBCC, 0, 1, 0);
        check("lb_addr", last_addr, 32'h0000_0100);
        check("lb_be", 32'(last_be), 32'b1000);
        check("lb_data", out_data, 32'hFFFF_FF80);
        issue(32'h0000_0103, 32'd0, 1, 0, 2'd0, 1, 5'd7, 1, 32'h80AA_BBCC, 0, 1, 0);
        check("lbu_data", out_data, 32'h0000_0080);

        // SH at 0x202
        issue(32'h0000_0202, 32'hDEAD_BEEF, 0, 1, 2'd1, 0, 5'd9, 1, 32'd0, 0, 1, 0);
        check("sh_be", 32'(last_be), 32'b1100);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_we", 32'(last_we), 32'd1);
        check("sh_rd_we", 32'(out_rd_we), 32'd0);

        // misaligned LW at 0x101
        issue(32'h0000_0101, 32'd0, 1, 0, 2'd2, 0, 5'd3, 1, 32'd0, 0, 0, 0);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_rd_we", 32'(out_rd_we), 32'd0);
        check("mis_data", out_data, 32'h0000_0101);

        // LW with grant held off 3 cycles, then gnt+rvalid together
        issue(32'h0000_0300, 32'd0, 1, 0, 2'd2, 0, 5'd11, 1, 32'hCAFE_F00D, 3, 0, 0);
        check("lw_data", out_data, 32'hCAFE_F00D);

        // halfword loads
        issue(32'h0000_0202, 32'd0, 1, 0, 2'd1, 0, 5'd12, 1, 32'h8001_7FFE, 1, 2, 0);
        check("lh_hi_data", out_data, 32'hFFFF_8001);
        issue(32'h0000_0202, 32'd0, 1, 0, 2'd1, 1, 5'd12, 1, 32'h8001_7FFE, 0, 1, 0);
        check("lhu_hi_data", out_data, 32'h0000_8001);
        issue(32'h0000_0200, 32'd0, 1, 0, 2'd1, 0, 5'd12, 1, 32'h8001_7FFE, 0, 0, 0);
        check("lh_lo_data", out_data, 32'h0000_7FFE);

        // SB at 0x101, misaligned LH at 0x201, reserved size as word
        issue(32'h0000_0101, 32'h1234_5677, 0, 1, 2'd0, 0, 5'd1, 1, 32'd0, 0, 1, 0);
        check("sb_be", 32'(last_be), 32'b0010);
        check("sb_wdata", last_wdata, 32'h7777_7777);
        issue(32'h0000_0201, 32'd0, 1, 0, 2'd1, 0, 5'd2, 1, 32'd0, 0, 0, 0);
        check("mis_lh_flag", 32'(misaligned), 32'd1);
        issue(32'h0000_0404, 32'd0, 1, 0, 2'd3, 1, 5'd4, 1, 32'h89AB_CDEF, 0, 1, 0);
        check("rsvd_word_data", out_data, 32'h89AB_CDEF);

        // never granted: bus error after TMO cycles in REQ
        issue(32'h0000_0500, 32'd0, 1, 0, 2'd2, 0, 5'd6, 1, 32'd0, 0, 0, 1);
        check("berr_data", out_data, 32'd0);
        check("berr_rd_we", 32'(out_rd_we), 32'd0);

        // reset in the middle of RESP; a late rvalid must be ignored
        alu_out = 32'h0000_0600; mem_read = 1'b1; mem_size = 2'd2; rd_addr = 5'd8; rd_we = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("pre_rst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_ignored", 32'(out_valid), 32'd0);

        // stage still works after the reset
        issue(32'h0BAD_F00D, 32'd0, 0, 0, 2'd0, 0, 5'd31, 0, 32'd0, 0, 0, 0);
        check("post_rst_pass", out_data, 32'h0BAD_F00D);

        @(posedge clk); #1;
        check("model_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
